// File: rtl/current_adc_reader_if.sv
// SPI-style link between the current-sense reader and its 12-bit ADC.
// The reader is the master; the ADC (or a bench model of it) is the slave.
interface current_adc_reader_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_miso;

  modport master (output adc_cs_n, output adc_sclk, input adc_miso);
  modport slave  (input adc_cs_n, input adc_sclk, output adc_miso);
endinterface

// File: rtl/current_adc_reader.sv
// Periodic MCP3201-style ADC reader with block averaging of 2^AVG_LOG2 samples.
// Feeds current_b_out to the over-current supervision stage.
module current_adc_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 5000,
  parameter int AVG_LOG2      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  current_adc_reader_if.master        adc,
  output logic [11:0]                 raw_sample,
  output logic                        raw_valid,
  output logic [11:0]                 current_b_out,
  output logic                        current_valid,
  output logic                        frame_overrun
);

  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int NW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int AW = 12 + AVG_LOG2;

  localparam logic [TW-1:0] TICK_AT   = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PER_END   = CW'(2 * CLK_DIV - 1);
  localparam logic [NW-1:0] LAST_SLOT = NW'((1 << AVG_LOG2) - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd14;
  localparam logic [3:0]    FIRST_DAT = 4'd3;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer;
  logic            tick;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      bit_idx, bit_n;
  logic            sclk_q, sclk_n;
  logic            cs_q, cs_n_n;
  logic            shift_en;
  logic            done;
  logic [11:0]     shreg;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   sum;
  logic [NW-1:0]   count;

  assign tick         = enable && (timer == TICK_AT);
  assign sum          = acc + AW'(shreg);
  assign adc.adc_cs_n = cs_q;
  assign adc.adc_sclk = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!enable || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sclk_q  <= sclk_n;
      cs_q    <= cs_n_n;
    end
  end

  // SCLK and CS are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    sclk_n   = 1'b0;
    cs_n_n   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        cs_n_n = 1'b1;
        cnt_n  = '0;
        bit_n  = '0;
        if (tick) begin
          state_n = SETUP;
          cs_n_n  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == HALF_END) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == PER_END) begin
          shift_en = 1'b1;
          cnt_n    = '0;
          if (bit_idx == LAST_BIT) begin
            state_n = HOLD;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end else begin
          cnt_n  = cnt + CW'(1);
          sclk_n = (cnt >= HALF_END);
        end
      end
      HOLD: begin
        if (cnt == HALF_END) begin
          state_n = IDLE;
          cs_n_n  = 1'b1;
          done    = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cs_n_n  = 1'b1;
      end
    endcase
  end

  // The first three bits of a frame are the sample and null bits and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_en && (bit_idx >= FIRST_DAT)) begin
      shreg <= {shreg[10:0], adc.adc_miso};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_sample    <= '0;
      raw_valid     <= 1'b0;
      current_b_out <= '0;
      current_valid <= 1'b0;
      acc           <= '0;
      count         <= '0;
    end else begin
      raw_valid     <= done;
      current_valid <= 1'b0;
      if (done) begin
        raw_sample <= shreg;
        if (count == LAST_SLOT) begin
          current_b_out <= sum[AVG_LOG2 +: 12];
          current_valid <= 1'b1;
          acc           <= '0;
          count         <= '0;
        end else begin
          acc   <= sum;
          count <= count + NW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_overrun <= 1'b0;
    end else if (tick && (state != IDLE)) begin
      frame_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_current_adc_reader.sv
// Bench for current_adc_reader: three instances (averaging, AVG_LOG2=0, overrun-prone
// period) each driven by an ADC model and checked against an arithmetic reference.
module tb_current_adc_reader;

  typedef struct {
    logic [14:0] word0;
    logic [11:0] exp_raw;
    logic        exp_cv;
    logic [11:0] exp_cur;
    logic [11:0] word1;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] miso_r = 3'b000;

  wire [2:0]  cs_w, sclk_w, rv_w, cv_w, ovr_w;
  wire [11:0] raw_w [3];
  wire [11:0] cur_w [3];

  current_adc_reader_if spi0 ();
  current_adc_reader_if spi1 ();
  current_adc_reader_if spi2 ();

  assign spi0.adc_miso = miso_r[0];
  assign spi1.adc_miso = miso_r[1];
  assign spi2.adc_miso = miso_r[2];
  assign cs_w   = {spi2.adc_cs_n, spi1.adc_cs_n, spi0.adc_cs_n};
  assign sclk_w = {spi2.adc_sclk, spi1.adc_sclk, spi0.adc_sclk};

  current_adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .AVG_LOG2(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc(spi0),
    .raw_sample(raw_w[0]), .raw_valid(rv_w[0]), .current_b_out(cur_w[0]),
    .current_valid(cv_w[0]), .frame_overrun(ovr_w[0]));

  current_adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .AVG_LOG2(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc(spi1),
    .raw_sample(raw_w[1]), .raw_valid(rv_w[1]), .current_b_out(cur_w[1]),
    .current_valid(cv_w[1]), .frame_overrun(ovr_w[1]));

  current_adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(50), .AVG_LOG2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc(spi2),
    .raw_sample(raw_w[2]), .raw_valid(rv_w[2]), .current_b_out(cur_w[2]),
    .current_valid(cv_w[2]), .frame_overrun(ovr_w[2]));

  always #5 clk = ~clk;

  int          assertions = 0;
  int          failures   = 0;
  vec_t        vecs [12];
  logic [14:0] words [3][64];
  int          fidx [3];
  int          bpos [3];
  int          msum [3];
  int          mcnt [3];
  int          falls [3];
  int          last_fall [3];
  int          lg [3];
  logic [2:0]  prev_cs   = 3'b111;
  logic [2:0]  prev_sclk = 3'b000;
  int          rises, hiw, lowlen, cyc;
  bit          hibad;

  task automatic checkOutput(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model, ADC model and framing monitor, evaluated once per falling clk edge.
  task automatic monitorStep();
    logic [11:0] smp;
    bit          exp_cv;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        msum[i] = 0;
        mcnt[i] = 0;
      end
      if (rv_w[i] === 1'b1) begin
        smp = words[i][fidx[i]][11:0];
        checkOutput($sformatf("raw_sample%0d", i), int'(raw_w[i]), int'(smp));
        checkOutput($sformatf("raw_valid_at_cs_rise%0d", i), int'({prev_cs[i], cs_w[i]}), 1);
        exp_cv = ((mcnt[i] + 1) == (1 << lg[i]));
        checkOutput($sformatf("current_valid%0d", i), int'(cv_w[i]), int'(exp_cv));
        if (exp_cv) begin
          checkOutput($sformatf("current_b_out%0d", i), int'(cur_w[i]),
                      (msum[i] + int'(smp)) / (1 << lg[i]));
          msum[i] = 0;
          mcnt[i] = 0;
        end else begin
          msum[i] += int'(smp);
          mcnt[i]++;
        end
        if (i == 0) begin
          checkOutput("sclk_rises_per_frame", rises, 15);
          checkOutput("sclk_high_width_bad", int'(hibad), 0);
          checkOutput("cs_low_cycles", lowlen, 64);
        end
      end else if (cv_w[i] === 1'b1) begin
        checkOutput($sformatf("current_valid_without_raw%0d", i), int'(cv_w[i]), 0);
      end
      if (prev_cs[i] && !cs_w[i]) begin
        falls[i]++;
        if (last_fall[i] >= 0) checkOutput($sformatf("cs_period%0d", i), cyc - last_fall[i], 100);
        last_fall[i] = cyc;
        bpos[i] = 0;
        miso_r[i] = words[i][fidx[i]][14];
        if (i == 0) begin
          rises = 0; hiw = 0; hibad = 1'b0; lowlen = 0;
        end
      end else if (!cs_w[i] && prev_sclk[i] && !sclk_w[i]) begin
        bpos[i]++;
        if (bpos[i] < 15) miso_r[i] = words[i][fidx[i]][14 - bpos[i]];
      end
      if (i == 0 && !cs_w[0]) begin
        lowlen++;
        if (!prev_sclk[0] && sclk_w[0]) rises++;
        if (sclk_w[0]) hiw++;
        if (prev_sclk[0] && !sclk_w[0]) begin
          if (hiw != 2) hibad = 1'b1;
          hiw = 0;
        end
      end
      if (!prev_cs[i] && cs_w[i]) fidx[i] = (fidx[i] + 1) % 64;
      prev_cs[i]   = cs_w[i];
      prev_sclk[i] = sclk_w[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitorStep();
  endtask

  task automatic waitRaw(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (rv_w[0] !== 1'b1 && n < 300);
    checkOutput(name, int'(rv_w[0]), 1);
  endtask

  task automatic waitCsFall();
    int n = 0;
    while (cs_w[0] !== 1'b1 && n < 200) begin tick(); n++; end
    while (cs_w[0] !== 1'b0 && n < 400) begin tick(); n++; end
    checkOutput("cs_fall_seen", int'(cs_w[0]), 0);
  endtask

  task automatic applyStimulus(input int k);
    waitRaw($sformatf("vec%0d_raw_valid", k));
    checkOutput($sformatf("vec%0d_raw", k), int'(raw_w[0]), int'(vecs[k].exp_raw));
    checkOutput($sformatf("vec%0d_cv", k), int'(cv_w[0]), int'(vecs[k].exp_cv));
    if (vecs[k].exp_cv) checkOutput($sformatf("vec%0d_cur", k), int'(cur_w[0]), int'(vecs[k].exp_cur));
    checkOutput($sformatf("vec%0d_l0_raw", k), int'(raw_w[1]), int'(vecs[k].word1));
    checkOutput($sformatf("vec%0d_l0_cv", k), int'(cv_w[1]), 1);
    checkOutput($sformatf("vec%0d_l0_cur", k), int'(cur_w[1]), int'(vecs[k].word1));
  endtask

  initial begin
    int f0;
    rst_n = 1'b0;
    lg = '{2, 0, 2};
    last_fall = '{-1, -1, -1};

    vecs[0]  = '{15'h7A5C, 12'hA5C, 1'b0, 12'h000, 12'h9C4};
    vecs[1]  = '{15'h2001, 12'h001, 1'b0, 12'h000, 12'h9C3};
    vecs[2]  = '{15'h5800, 12'h800, 1'b0, 12'h000, 12'h123};
    vecs[3]  = '{15'h07FF, 12'h7FF, 1'b1, 12'h697, 12'h456};
    vecs[4]  = '{15'h73E8, 12'h3E8, 1'b0, 12'h000, 12'h000};
    vecs[5]  = '{15'h13E9, 12'h3E9, 1'b0, 12'h000, 12'hFFF};
    vecs[6]  = '{15'h63EA, 12'h3EA, 1'b0, 12'h000, 12'h555};
    vecs[7]  = '{15'h33EB, 12'h3EB, 1'b1, 12'h3E9, 12'hAAA};
    vecs[8]  = '{15'h7FFF, 12'hFFF, 1'b0, 12'h000, 12'h001};
    vecs[9]  = '{15'h0FFF, 12'hFFF, 1'b0, 12'h000, 12'h7FF};
    vecs[10] = '{15'h4FFF, 12'hFFF, 1'b0, 12'h000, 12'h800};
    vecs[11] = '{15'h2FFF, 12'hFFF, 1'b1, 12'hFFF, 12'h3E8};

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 64; k++) words[i][k] = 15'($urandom);
    for (int k = 0; k < 12; k++) begin
      words[0][k] = vecs[k].word0;
      words[1][k] = {3'($urandom), vecs[k].word1};
    end

    repeat (3) tick();
    checkOutput("reset_cs_n", int'(cs_w[0]), 1);
    checkOutput("reset_sclk", int'(sclk_w[0]), 0);
    checkOutput("reset_raw_sample", int'(raw_w[0]), 0);
    checkOutput("reset_raw_valid", int'(rv_w[0]), 0);
    checkOutput("reset_current_b_out", int'(cur_w[0]), 0);
    checkOutput("reset_current_valid", int'(cv_w[0]), 0);
    checkOutput("reset_overrun", int'(ovr_w[0]), 0);

    $display("[TB] releasing reset with enable high");
    enable = 1'b1;
    rst_n  = 1'b1;
    repeat (49) tick();
    checkOutput("p50_cs_before_first_tick", int'(cs_w[2]), 1);
    tick();
    checkOutput("p50_cs_first_fall", int'(cs_w[2]), 0);
    repeat (48) tick();
    checkOutput("p50_overrun_before_second_tick", int'(ovr_w[2]), 0);
    tick();
    checkOutput("cs_before_first_tick", int'(cs_w[0]), 1);
    tick();
    checkOutput("cs_first_fall_at_100", int'(cs_w[0]), 0);
    checkOutput("p50_overrun_after_second_tick", int'(ovr_w[2]), 1);

    for (int k = 0; k < 12; k++) applyStimulus(k);
    checkOutput("p50_overrun_sticky", int'(ovr_w[2]), 1);

    $display("[TB] asynchronous reset in the middle of a frame");
    waitRaw("pre_reset_frame_a");
    waitRaw("pre_reset_frame_b");
    waitCsFall();
    repeat ($urandom_range(8, 40)) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_cs_n", int'(cs_w[0]), 1);
    checkOutput("async_reset_sclk", int'(sclk_w[0]), 0);
    checkOutput("async_reset_current", int'(cur_w[0]), 0);
    checkOutput("async_reset_overrun", int'(ovr_w[2]), 0);
    last_fall = '{-1, -1, -1};
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) waitRaw("post_reset_frame");

    $display("[TB] dropping enable in the middle of a frame");
    waitCsFall();
    repeat ($urandom_range(5, 55)) tick();
    enable = 1'b0;
    waitRaw("frame_completes_after_disable");
    f0 = falls[0];
    repeat (300) tick();
    checkOutput("no_cs_while_disabled", falls[0] - f0, 0);
    checkOutput("cs_idle_while_disabled", int'(cs_w[0]), 1);
    last_fall = '{-1, -1, -1};
    enable = 1'b1;
    repeat (99) tick();
    checkOutput("reenable_cs_before_tick", int'(cs_w[0]), 1);
    tick();
    checkOutput("reenable_cs_fall_at_100", int'(cs_w[0]), 0);

    $display("[TB] random sample stream");
    repeat (30) waitRaw("random_frame");
    checkOutput("final_overrun_p50", int'(ovr_w[2]), 1);
    checkOutput("final_overrun_p100", int'(ovr_w[0]), 0);
    checkOutput("final_overrun_l0", int'(ovr_w[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
